// File: rtl/calc_key_entry.sv
// Keypad operand-entry controller: builds two 4-digit BCD operands and an
// operation code for the BCD ALU. Optional backspace support: CALC_ENTRY_BACKSPACE_EN.
module calc_key_entry (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [15:0] bcd1,
    output logic [15:0] bcd2,
    output logic [1:0]  op_selected,
    output logic [1:0]  disp_sel,
    output logic        result_valid,
    output logic        key_err
);

    // State encoding doubles as the display select code.
    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'b00,
        ST_ENTER_B  = 2'b01,
        ST_SHOW_RES = 2'b10
    } state_t;

    localparam logic [4:0] K_PLUS  = 5'd10;
    localparam logic [4:0] K_MINUS = 5'd11;
    localparam logic [4:0] K_EQ    = 5'd12;
    localparam logic [4:0] K_CLR   = 5'd13;
`ifdef CALC_ENTRY_BACKSPACE_EN
    localparam logic [4:0] K_BS    = 5'd14;
`endif

    state_t      state_r;
    logic [2:0]  cnt_a_r;
    logic [2:0]  cnt_b_r;
    logic [1:0]  op_latch_r;

    state_t      nxt_state_s;
    logic [15:0] nxt_a_s;
    logic [15:0] nxt_b_s;
    logic [2:0]  nxt_cnt_a_s;
    logic [2:0]  nxt_cnt_b_s;
    logic [1:0]  nxt_op_s;
    logic        nxt_err_s;

    function automatic logic is_digit(input logic [4:0] code);
        return (code <= 5'd9);
    endfunction

    function automatic logic is_op(input logic [4:0] code);
        return (code == K_PLUS) || (code == K_MINUS);
    endfunction

    function automatic logic [1:0] op_code(input logic [4:0] code);
        return (code == K_PLUS) ? 2'b01 : 2'b10;
    endfunction

    // Next-state decode of one key event.
    always_comb begin
        nxt_state_s = state_r;
        nxt_a_s     = bcd1;
        nxt_b_s     = bcd2;
        nxt_cnt_a_s = cnt_a_r;
        nxt_cnt_b_s = cnt_b_r;
        nxt_op_s    = op_latch_r;
        nxt_err_s   = 1'b0;
        if (!key_valid) begin
            nxt_err_s = 1'b0;
        end else if (key_code == K_CLR) begin
            nxt_state_s = ST_ENTER_A;
            nxt_a_s     = 16'h0000;
            nxt_b_s     = 16'h0000;
            nxt_cnt_a_s = 3'd0;
            nxt_cnt_b_s = 3'd0;
            nxt_op_s    = 2'b00;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (is_digit(key_code)) begin
                        if (cnt_a_r != 3'd4) begin
                            nxt_a_s     = {bcd1[11:0], key_code[3:0]};
                            nxt_cnt_a_s = cnt_a_r + 3'd1;
                        end else begin
                            nxt_err_s = 1'b1;
                        end
                    end else if (is_op(key_code)) begin
                        nxt_op_s    = op_code(key_code);
                        nxt_state_s = ST_ENTER_B;
`ifdef CALC_ENTRY_BACKSPACE_EN
                    end else if ((key_code == K_BS) && (cnt_a_r != 3'd0)) begin
                        nxt_a_s     = {4'h0, bcd1[15:4]};
                        nxt_cnt_a_s = cnt_a_r - 3'd1;
`endif
                    end else begin
                        nxt_err_s = 1'b1;
                    end
                end
                ST_ENTER_B: begin
                    if (is_digit(key_code)) begin
                        if (cnt_b_r != 3'd4) begin
                            nxt_b_s     = {bcd2[11:0], key_code[3:0]};
                            nxt_cnt_b_s = cnt_b_r + 3'd1;
                        end else begin
                            nxt_err_s = 1'b1;
                        end
                    end else if (is_op(key_code)) begin
                        if (cnt_b_r == 3'd0) begin
                            nxt_op_s = op_code(key_code);
                        end else begin
                            nxt_err_s = 1'b1;
                        end
                    end else if (key_code == K_EQ) begin
                        nxt_state_s = ST_SHOW_RES;
`ifdef CALC_ENTRY_BACKSPACE_EN
                    end else if (key_code == K_BS) begin
                        if (cnt_b_r != 3'd0) begin
                            nxt_b_s     = {4'h0, bcd2[15:4]};
                            nxt_cnt_b_s = cnt_b_r - 3'd1;
                        end else begin
                            nxt_state_s = ST_ENTER_A;
                            nxt_op_s    = 2'b00;
                        end
`endif
                    end else begin
                        nxt_err_s = 1'b1;
                    end
                end
                ST_SHOW_RES: begin
                    // A digit starts a fresh calculation with that digit as A.
                    if (is_digit(key_code)) begin
                        nxt_state_s = ST_ENTER_A;
                        nxt_a_s     = {12'h000, key_code[3:0]};
                        nxt_b_s     = 16'h0000;
                        nxt_cnt_a_s = 3'd1;
                        nxt_cnt_b_s = 3'd0;
                        nxt_op_s    = 2'b00;
                    end else begin
                        nxt_err_s = 1'b1;
                    end
                end
                default: begin
                    nxt_state_s = ST_ENTER_A;
                    nxt_a_s     = 16'h0000;
                    nxt_b_s     = 16'h0000;
                    nxt_cnt_a_s = 3'd0;
                    nxt_cnt_b_s = 3'd0;
                    nxt_op_s    = 2'b00;
                end
            endcase
        end
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r      <= ST_ENTER_A;
            cnt_a_r      <= 3'd0;
            cnt_b_r      <= 3'd0;
            op_latch_r   <= 2'b00;
            bcd1         <= 16'h0000;
            bcd2         <= 16'h0000;
            op_selected  <= 2'b00;
            disp_sel     <= 2'b00;
            result_valid <= 1'b0;
            key_err      <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            cnt_a_r      <= nxt_cnt_a_s;
            cnt_b_r      <= nxt_cnt_b_s;
            op_latch_r   <= nxt_op_s;
            bcd1         <= nxt_a_s;
            bcd2         <= nxt_b_s;
            op_selected  <= (nxt_state_s == ST_SHOW_RES) ? nxt_op_s : 2'b00;
            disp_sel     <= nxt_state_s;
            result_valid <= (nxt_state_s == ST_SHOW_RES);
            key_err      <= nxt_err_s;
        end
    end

endmodule

// File: tb/tb_calc_key_entry.sv
// Self-checking bench for calc_key_entry: directed scenarios plus random key
// streams checked against a digit-queue model of the calculator entry rules.
module tb_calc_key_entry;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic [15:0] bcd1;
    logic [15:0] bcd2;
    logic [1:0]  op_selected;
    logic [1:0]  disp_sel;
    logic        result_valid;
    logic        key_err;

    int checks = 0;
    int errors = 0;

`ifdef CALC_ENTRY_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    calc_key_entry dut (
        .clk(clk), .clear_n(clear_n), .key_valid(key_valid), .key_code(key_code),
        .bcd1(bcd1), .bcd2(bcd2), .op_selected(op_selected), .disp_sel(disp_sel),
        .result_valid(result_valid), .key_err(key_err)
    );

    always #5 clk = ~clk;

    // Model: operands as lists of entered digits, mode 0=A 1=B 2=result.
    int a_q[$];
    int b_q[$];
    int m_mode = 0;
    int m_op = 0;
    bit m_err = 1'b0;

    function automatic logic [15:0] pack_a();
        logic [15:0] v = 16'h0000;
        foreach (a_q[i]) v = (v << 4) | 16'(a_q[i]);
        return v;
    endfunction

    function automatic logic [15:0] pack_b();
        logic [15:0] v = 16'h0000;
        foreach (b_q[i]) v = (v << 4) | 16'(b_q[i]);
        return v;
    endfunction

    function automatic logic [15:0] exp_bcd1(); return pack_a(); endfunction
    function automatic logic [15:0] exp_bcd2(); return pack_b(); endfunction
    function automatic logic [1:0] exp_op(); return (m_mode == 2) ? 2'(m_op) : 2'b00; endfunction
    function automatic logic [1:0] exp_disp(); return 2'(m_mode); endfunction
    function automatic logic exp_rv(); return (m_mode == 2); endfunction

    task automatic model_reset();
        a_q.delete(); b_q.delete(); m_mode = 0; m_op = 0; m_err = 1'b0;
    endtask

    task automatic model_key(input int c);
        m_err = 1'b0;
        if (c == 13) begin
            model_reset();
        end else if (m_mode == 2) begin
            if (c <= 9) begin
                model_reset();
                a_q.push_back(c);
            end else m_err = 1'b1;
        end else if (c <= 9) begin
            if (m_mode == 0) begin
                if (a_q.size() < 4) a_q.push_back(c); else m_err = 1'b1;
            end else begin
                if (b_q.size() < 4) b_q.push_back(c); else m_err = 1'b1;
            end
        end else if (c == 10 || c == 11) begin
            if (m_mode == 0) begin
                m_op = (c == 10) ? 1 : 2; m_mode = 1;
            end else if (b_q.size() == 0) m_op = (c == 10) ? 1 : 2;
            else m_err = 1'b1;
        end else if (c == 12) begin
            if (m_mode == 1) m_mode = 2; else m_err = 1'b1;
        end else if (c == 14 && BS_EN) begin
            if (m_mode == 0) begin
                if (a_q.size() > 0) void'(a_q.pop_back()); else m_err = 1'b1;
            end else begin
                if (b_q.size() > 0) void'(b_q.pop_back());
                else begin m_mode = 0; m_op = 0; end
            end
        end else m_err = 1'b1;
    endtask

    task automatic press(input int c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'(c);
        model_key(c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'($urandom_range(0, 31));
        m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bcd1 !== 16'h0000) begin errors++; $display("FAIL reset_bcd1 got %h exp 0000", bcd1); end
        checks++; if (bcd2 !== 16'h0000) begin errors++; $display("FAIL reset_bcd2 got %h exp 0000", bcd2); end
        checks++; if (op_selected !== 2'b00) begin errors++; $display("FAIL reset_op got %b exp 00", op_selected); end
        checks++; if (disp_sel !== 2'b00) begin errors++; $display("FAIL reset_disp got %b exp 00", disp_sel); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", result_valid); end
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", key_err); end
        clear_n = 1'b1;
        model_reset();
    endtask

    task automatic test_digit_overflow();
        press(13);
        for (int d = 1; d <= 5; d++) begin
            press(d);
            checks++; if (bcd1 !== exp_bcd1() || key_err !== m_err) begin
                errors++; $display("FAIL ovf_digit%0d got bcd1=%h err=%b exp %h %b", d, bcd1, key_err, exp_bcd1(), m_err);
            end
        end
        checks++; if (bcd1 !== 16'h1234 || key_err !== 1'b1 || disp_sel !== 2'b00) begin
            errors++; $display("FAIL ovf_fifth got bcd1=%h err=%b disp=%b exp 1234 1 00", bcd1, key_err, disp_sel);
        end
        idle();
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL ovf_err_pulse got %b exp 0", key_err); end
    endtask

    task automatic test_add();
        int keys[4] = '{7, 10, 3, 12};
        press(13);
        for (int i = 0; i < 3; i++) begin
            press(keys[i]);
            checks++; if (op_selected !== 2'b00) begin errors++; $display("FAIL add_op_early step%0d got %b exp 00", i, op_selected); end
        end
        press(keys[3]);
        checks++; if (bcd1 !== 16'h0007 || bcd2 !== 16'h0003) begin
            errors++; $display("FAIL add_operands got %h %h exp 0007 0003", bcd1, bcd2);
        end
        checks++; if (op_selected !== 2'b01 || disp_sel !== 2'b10 || result_valid !== 1'b1) begin
            errors++; $display("FAIL add_result got op=%b disp=%b rv=%b exp 01 10 1", op_selected, disp_sel, result_valid);
        end
    endtask

    task automatic test_op_replace();
        int keys[5] = '{5, 10, 11, 2, 10};
        press(13);
        foreach (keys[i]) press(keys[i]);
        checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL oprep_reject got %b exp 1", key_err); end
        press(12);
        checks++; if (op_selected !== 2'b10 || bcd2 !== 16'h0002) begin
            errors++; $display("FAIL oprep_minus got op=%b bcd2=%h exp 10 0002", op_selected, bcd2);
        end
        press(10);
        checks++; if (key_err !== 1'b1 || result_valid !== 1'b1) begin
            errors++; $display("FAIL oprep_show_op got err=%b rv=%b exp 1 1", key_err, result_valid);
        end
    endtask

    task automatic test_show_digit();
        press(9);
        checks++; if (bcd1 !== 16'h0009 || bcd2 !== 16'h0000 || disp_sel !== 2'b00 ||
                      op_selected !== 2'b00 || result_valid !== 1'b0 || key_err !== 1'b0) begin
            errors++; $display("FAIL show_digit got %h %h disp=%b op=%b rv=%b err=%b exp 0009 0000 00 00 0 0",
                               bcd1, bcd2, disp_sel, op_selected, result_valid, key_err);
        end
    endtask

    task automatic test_async_reset();
        int keys[4] = '{4, 2, 11, 6};
        press(13);
        foreach (keys[i]) press(keys[i]);
        @(negedge clk);
        key_valid = 1'b0;
        #1 clear_n = 1'b0;
        #1;
        checks++; if (bcd1 !== 16'h0000 || bcd2 !== 16'h0000 || disp_sel !== 2'b00 ||
                      op_selected !== 2'b00 || result_valid !== 1'b0 || key_err !== 1'b0) begin
            errors++; $display("FAIL async_reset got %h %h disp=%b op=%b rv=%b err=%b exp all zero",
                               bcd1, bcd2, disp_sel, op_selected, result_valid, key_err);
        end
        #1 clear_n = 1'b1;
        model_reset();
        key_valid = 1'b1;
        key_code  = 5'd8;
        model_key(8);
        @(posedge clk);
        #1;
        checks++; if (bcd1 !== 16'h0008 || disp_sel !== 2'b00) begin
            errors++; $display("FAIL first_key got bcd1=%h disp=%b exp 0008 00", bcd1, disp_sel);
        end
    endtask

    task automatic test_backspace();
        logic [15:0] want_a;
        logic        want_err;
        int keys[5] = '{13, 1, 2, 3, 14};
        want_a   = BS_EN ? 16'h0012 : 16'h0123;
        want_err = !BS_EN;
        foreach (keys[i]) press(keys[i]);
        checks++; if (bcd1 !== want_a || key_err !== want_err) begin
            errors++; $display("FAIL backspace got bcd1=%h err=%b exp %h %b", bcd1, key_err, want_a, want_err);
        end
        press(11); press(14);
        checks++; if (disp_sel !== exp_disp() || key_err !== m_err || bcd1 !== exp_bcd1()) begin
            errors++; $display("FAIL backspace_b got disp=%b err=%b bcd1=%h exp %b %b %h",
                               disp_sel, key_err, bcd1, exp_disp(), m_err, exp_bcd1());
        end
    endtask

    task automatic test_random();
        int c;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: c = $urandom_range(0, 9);
                    5:       c = $urandom_range(10, 11);
                    6:       c = 12;
                    7:       c = ($urandom_range(0, 3) == 0) ? 13 : 14;
                    default: c = $urandom_range(0, 31);
                endcase
                press(c);
            end
            checks++;
            if (bcd1 !== exp_bcd1() || bcd2 !== exp_bcd2() || op_selected !== exp_op() ||
                disp_sel !== exp_disp() || result_valid !== exp_rv() || key_err !== m_err) begin
                errors++;
                $display("FAIL random_step%0d got %h %h op=%b disp=%b rv=%b err=%b exp %h %h %b %b %b %b",
                         n, bcd1, bcd2, op_selected, disp_sel, result_valid, key_err,
                         exp_bcd1(), exp_bcd2(), exp_op(), exp_disp(), exp_rv(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digit_overflow();
        test_add();
        test_op_replace();
        test_show_digit();
        test_async_reset();
        test_backspace();
        test_random();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
